dmem_responder: RTL and testbench

- Data-memory responder for the load/store port of the pipelined MIPS core.
- Sits opposite the MEM stage:
  - accepts one load or store request at a time;
  - holds the pipeline with a stall signal for a programmable access latency;
  - performs the access;
  - returns a one-cycle response pulse with read data or an address-error flag.

---
 rtl/dmem_responder.sv | 94 +++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable access latency for the MEM stage
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic [DATA_W-1:0] mem_array [DEPTH];

  // Full-width compare so large addresses never alias into the array
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              access;

  assign in_range = (lat_addr < ADDR_W'(DEPTH));
  assign idx      = lat_addr[IDX_W-1:0];
  assign access   = (state == BUSY) && (cnt == 4'd0);

  // Stall follows the request in IDLE so the pipeline freezes on the accepting cycle
  assign mem_stall = (state == BUSY) || ((state == IDLE) && req_valid);
  assign rsp_valid = (state == DONE);

  // Control FSM: latch request, count down the latency, commit the access, pulse DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      addr_err  <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            cnt       <= 4'(LATENCY - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            addr_err <= ~in_range;
            if (!lat_write) begin
              rsp_rdata <= in_range ? mem_array[idx] : '0;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store commit on the BUSY->DONE edge; reset forces IDLE first so an aborted store never lands
  always_ff @(posedge clk) begin
    if (access && lat_write && in_range) begin
      mem_array[idx] <= lat_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with randomized loads/stores
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int LATENCY = 2;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              mem_stall;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              addr_err;

  dmem_responder #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_stall(mem_stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] last_rdata;
  logic [DATA_W:0]   exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: apply one request at the architectural level and queue its response
  task automatic model_req(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic ok;
    logic [DATA_W-1:0] rd;
    ok = (a < DEPTH);
    if (!w) begin
      rd = ok ? model_mem[a[7:0]] : '0;
      last_rdata = rd;
    end else begin
      if (ok) model_mem[a[7:0]] = d;
      rd = last_rdata;
    end
    exp_q.push_back({~ok, rd});
  endtask

  // Called just after a posedge with the DUT in IDLE; returns just after the DONE->IDLE edge
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int gap);
    bit seen;
    if (gap > 0) begin
      req_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    model_req(w, a, d);
    @(posedge clk); #1;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = $urandom_range(0, 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Monitor: count stall cycles per request and compare each response with the scoreboard
  int stall_cnt = 0;
  bit overlap = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      stall_cnt = 0;
      overlap   = 1'b0;
    end else begin
      if (mem_stall && rsp_valid) overlap = 1'b1;
      if (mem_stall) stall_cnt++;
      if (rsp_valid) begin
        logic [DATA_W:0] e;
        check("stall_cycles", 32'(stall_cnt), 32'(LATENCY + 1));
        check("no_overlap", {31'd0, overlap}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e[DATA_W-1:0]);
          check("addr_err", {31'd0, addr_err}, {31'd0, e[DATA_W]});
        end
        stall_cnt = 0;
        overlap   = 1'b0;
      end
    end
  end

  initial begin
    int mism;
    logic [ADDR_W-1:0] a;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    last_rdata = '0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = $urandom;
      dut.mem_array[i] = model_mem[i];
    end
    model_mem[5] = 32'd15;
    dut.mem_array[5] = 32'd15;
    repeat (2) @(posedge clk);
    #2;
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    issue(1'b0, 32'd5, 32'd0, 0);
    issue(1'b1, 32'd7, 32'd60, 0);
    issue(1'b0, 32'd7, 32'd0, 0);
    issue(1'b0, 32'd300, 32'd0, 1);
    issue(1'b1, 32'd256, 32'hDEAD_BEEF, 0);
    issue(1'b0, 32'hFFFF_0005, 32'd0, 0);

    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'd9;
    req_wdata = 32'hAA;
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check("abort_stall", {31'd0, mem_stall}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_addr_err", {31'd0, addr_err}, 32'd0);
    last_rdata = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_mem9", dut.mem_array[9], model_mem[9]);
    issue(1'b0, 32'd9, 32'd0, 1);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        7:       a = DEPTH + $urandom_range(0, 50);
        8:       a = {$urandom_range(1, 16'hFFFF), 16'd0} | 32'($urandom_range(0, 255));
        9:       a = $urandom_range(DEPTH - 1, DEPTH);
        default: a = $urandom_range(0, 15);
      endcase
      issue($urandom_range(0, 1), a, $urandom, $urandom_range(0, 2));
    end

    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (dut.mem_array[i] !== model_mem[i]) mism++;
    end
    check("array_contents", 32'(mism), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
